// File: rtl/ahb_lite_simple_master.sv
// AHB-Lite master that runs one SINGLE or INCR4 word transfer per command.
// Address/control and write data are registered; read beats and the
// completion status are reported as one-cycle pulses.
module ahb_lite_simple_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                HCLK,
    input  logic                HRESETn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic                cmd_burst4,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [4*DATA_W-1:0] cmd_wdata,

    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic [1:0]          rd_beat,
    output logic                done,
    output logic                done_err,

    output logic [ADDR_W-1:0]   HADDR,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [2:0]          HBURST,
    output logic [DATA_W-1:0]   HWDATA,
    input  logic [DATA_W-1:0]   HRDATA,
    input  logic                HREADY,
    input  logic [1:0]          HRESP
);

    localparam int unsigned BEATS = 4;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR4  = 3'b011;
    localparam logic [2:0] SIZE_WORD    = 3'b010;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    localparam logic [1:0]        LAST_BEAT  = 2'(BEATS - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_WORD = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ALIGN_BRST = ~ADDR_W'(15);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NSEQ,
        ST_SEQ,
        ST_LAST,
        ST_ERR
    } state_t;

    state_t                         state_q,     state_d;
    logic [ADDR_W-1:0]              haddr_q,     haddr_d;
    logic [1:0]                     htrans_q,    htrans_d;
    logic                           hwrite_q,    hwrite_d;
    logic [2:0]                     hburst_q,    hburst_d;
    logic [DATA_W-1:0]              hwdata_q,    hwdata_d;
    logic [BEATS-1:0][DATA_W-1:0]   wdata_q,     wdata_d;
    logic [1:0]                     a_beat_q,    a_beat_d;
    logic [1:0]                     d_beat_q,    d_beat_d;
    logic                           rd_valid_q,  rd_valid_d;
    logic [DATA_W-1:0]              rd_data_q,   rd_data_d;
    logic [1:0]                     rd_beat_q,   rd_beat_d;
    logic                           done_q,      done_d;
    logic                           done_err_q,  done_err_d;
    logic                           cmd_ready_q, cmd_ready_d;

    logic                           resp_err_c;

    // Any response other than OKAY is treated as ERROR.
    assign resp_err_c = (HRESP != RESP_OKAY);

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hburst_d    = hburst_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        a_beat_d    = a_beat_q;
        d_beat_d    = d_beat_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        rd_beat_d   = rd_beat_q;
        done_d      = 1'b0;
        done_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d  = ST_NSEQ;
                    htrans_d = TRANS_NONSEQ;
                    haddr_d  = cmd_addr & (cmd_burst4 ? ALIGN_BRST : ALIGN_WORD);
                    hwrite_d = cmd_write;
                    hburst_d = cmd_burst4 ? BURST_INCR4 : BURST_SINGLE;
                    wdata_d  = cmd_wdata;
                    a_beat_d = 2'd0;
                end
            end

            // First address phase; no data phase outstanding, HRESP is ignored.
            ST_NSEQ: begin
                if (HREADY) begin
                    d_beat_d = a_beat_q;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q[a_beat_q];
                    end
                    if (hburst_q == BURST_INCR4) begin
                        state_d  = ST_SEQ;
                        htrans_d = TRANS_SEQ;
                        haddr_d  = haddr_q + WORD_STEP;
                        a_beat_d = a_beat_q + 2'd1;
                    end else begin
                        state_d  = ST_LAST;
                        htrans_d = TRANS_IDLE;
                    end
                end
            end

            // Address of beat a_beat overlaps the data phase of beat d_beat.
            ST_SEQ: begin
                if (resp_err_c) begin
                    htrans_d = TRANS_IDLE;
                    if (HREADY) begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (HREADY) begin
                    if (!hwrite_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = HRDATA;
                        rd_beat_d  = d_beat_q;
                    end
                    d_beat_d = a_beat_q;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q[a_beat_q];
                    end
                    if (a_beat_q == LAST_BEAT) begin
                        state_d  = ST_LAST;
                        htrans_d = TRANS_IDLE;
                    end else begin
                        haddr_d  = haddr_q + WORD_STEP;
                        a_beat_d = a_beat_q + 2'd1;
                    end
                end
            end

            // Only the final data phase is left.
            ST_LAST: begin
                if (resp_err_c) begin
                    htrans_d = TRANS_IDLE;
                    if (HREADY) begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (HREADY) begin
                    if (!hwrite_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = HRDATA;
                        rd_beat_d  = d_beat_q;
                    end
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            // Second cycle of the ERROR response; the failed beat yields no data.
            ST_ERR: begin
                htrans_d = TRANS_IDLE;
                if (HREADY) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                htrans_d = TRANS_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            haddr_q     <= '0;
            htrans_q    <= TRANS_IDLE;
            hwrite_q    <= 1'b0;
            hburst_q    <= BURST_SINGLE;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            a_beat_q    <= 2'd0;
            d_beat_q    <= 2'd0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_beat_q   <= 2'd0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hburst_q    <= hburst_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            a_beat_q    <= a_beat_d;
            d_beat_q    <= d_beat_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_beat_q   <= rd_beat_d;
            done_q      <= done_d;
            done_err_q  <= done_err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // Output drive.
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = SIZE_WORD;
    assign HBURST    = hburst_q;
    assign HWDATA    = hwdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_beat   = rd_beat_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_ahb_lite_simple_master.sv
// Bench for ahb_lite_simple_master: directed scenarios plus random commands
// against a transaction-level model of the expected bus behaviour.
module tb_ahb_lite_simple_master;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic          cmd_burst4;
    logic [31:0]   cmd_addr;
    logic [127:0]  cmd_wdata;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic [1:0]    rd_beat;
    logic          done;
    logic          done_err;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADY;
    logic [1:0]    HRESP;

    ahb_lite_simple_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_burst4(cmd_burst4), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_beat(rd_beat),
        .done(done), .done_err(done_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit           write;
        bit           burst;
        logic [31:0]  addr;
        logic [127:0] wdata;
        int           err_beat;   // beat index answered with ERROR, -1 for none
        int           wait_beat;  // beat index that gets wait_n wait states
        int           wait_n;
        bit           rnd_wait;   // random waits and command gaps
    } cmd_t;

    cmd_t        cmd_q[$];
    cmd_t        cur;
    bit          busy, err_seen, dp_active, slv_err2, rnd_mode;
    int          k, beats, dp_beat, wait_left, gap;
    bit          exp_rd_valid, exp_done, exp_done_err;
    logic [31:0] exp_rd_data;
    logic [1:0]  exp_rd_beat;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] base_of(input cmd_t c);
        return c.burst ? {c.addr[31:4], 4'h0} : {c.addr[31:2], 2'b00};
    endfunction

    function automatic cmd_t mk(input bit w, input bit b, input logic [31:0] a,
                                input logic [127:0] d, input int eb, input int wb,
                                input int wn);
        cmd_t c;
        c.write = w; c.burst = b; c.addr = a; c.wdata = d;
        c.err_beat = eb; c.wait_beat = wb; c.wait_n = wn; c.rnd_wait = 1'b0;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.write     = 1'($urandom_range(0, 1));
        c.burst     = 1'($urandom_range(0, 1));
        c.addr      = $urandom;
        c.wdata     = {$urandom, $urandom, $urandom, $urandom};
        c.err_beat  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
        c.wait_beat = -1;
        c.wait_n    = 0;
        c.rnd_wait  = 1'b1;
        return c;
    endfunction

    // Expected DUT outputs for the current cycle, derived from bus progress.
    task automatic check_cycle();
        logic [1:0] exp_trans;
        exp_trans = (busy && !err_seen && k < beats) ? ((k == 0) ? 2'b10 : 2'b11) : 2'b00;
        chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
        chk("HSIZE", 32'(HSIZE), 32'h2);
        chk("HTRANS", 32'(HTRANS), 32'(exp_trans));
        if (exp_trans != 2'b00) begin
            chk("HADDR", HADDR, base_of(cur) + 32'(4 * k));
            chk("HWRITE", 32'(HWRITE), 32'(cur.write));
            chk("HBURST", 32'(HBURST), cur.burst ? 32'h3 : 32'h0);
        end
        if (dp_active && cur.write)
            chk("HWDATA", HWDATA, cur.wdata[32*dp_beat +: 32]);
        chk("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
        if (exp_rd_valid) begin
            chk("rd_data", rd_data, exp_rd_data);
            chk("rd_beat", 32'(rd_beat), 32'(exp_rd_beat));
        end
        chk("done", 32'(done), 32'(exp_done));
        if (exp_done)
            chk("done_err", 32'(done_err), 32'(exp_done_err));
    endtask

    // Command source and slave responses for the current cycle.
    task automatic drive_cycle();
        if (cmd_q.size() > 0 && gap == 0) begin
            cmd_valid  = 1'b1;
            cmd_write  = cmd_q[0].write;
            cmd_burst4 = cmd_q[0].burst;
            cmd_addr   = cmd_q[0].addr;
            cmd_wdata  = cmd_q[0].wdata;
        end else begin
            cmd_valid  = 1'b0;
            cmd_write  = 1'($urandom_range(0, 1));
            cmd_burst4 = 1'($urandom_range(0, 1));
            cmd_addr   = $urandom;
            cmd_wdata  = {$urandom, $urandom, $urandom, $urandom};
            if (gap > 0) gap--;
        end
        HRDATA = $urandom;
        if (dp_active) begin
            if (slv_err2) begin
                HREADY = 1'b1; HRESP = 2'($urandom_range(1, 3));
            end else if (wait_left > 0) begin
                HREADY = 1'b0; HRESP = 2'b00;
            end else if (dp_beat == cur.err_beat) begin
                HREADY = 1'b0; HRESP = 2'($urandom_range(1, 3));
            end else begin
                HREADY = 1'b1; HRESP = 2'b00;
            end
        end else begin
            HREADY = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            HRESP  = 2'($urandom_range(0, 3));
        end
    endtask

    // Advance the model by what happened on the bus at this edge.
    task automatic update_model();
        bit acc_addr, acc_cmd;
        acc_addr = busy && !err_seen && (k < beats) && HREADY;
        acc_cmd  = cmd_valid && !busy;
        exp_rd_valid = 1'b0; exp_done = 1'b0; exp_done_err = 1'b0;
        if (dp_active) begin
            if (HREADY && HRESP == 2'b00) begin
                if (!cur.write) begin
                    exp_rd_valid = 1'b1; exp_rd_data = HRDATA; exp_rd_beat = 2'(dp_beat);
                end
                dp_active = 1'b0;
                if (dp_beat == beats - 1) begin
                    exp_done = 1'b1; busy = 1'b0;
                end
            end else if (HREADY) begin
                exp_done = 1'b1; exp_done_err = 1'b1;
                busy = 1'b0; dp_active = 1'b0; err_seen = 1'b0; slv_err2 = 1'b0;
            end else if (HRESP != 2'b00) begin
                err_seen = 1'b1; slv_err2 = 1'b1;
            end else begin
                wait_left--;
            end
        end
        if (acc_addr) begin
            dp_active = 1'b1; dp_beat = k; k++;
            wait_left = (dp_beat == cur.wait_beat) ? cur.wait_n
                      : (cur.rnd_wait ? int'($urandom_range(0, 2)) : 0);
        end
        if (acc_cmd) begin
            cur = cmd_q.pop_front();
            busy = 1'b1; k = 0; err_seen = 1'b0;
            beats = cur.burst ? 4 : 1;
            gap = cur.rnd_wait ? int'($urandom_range(0, 2)) : 0;
        end
    endtask

    task automatic step();
        @(negedge HCLK);
        check_cycle();
        drive_cycle();
        @(posedge HCLK);
        update_model();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((busy || cmd_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(busy || cmd_q.size() != 0), 32'h0);
        step();
        step();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_HTRANS"}, 32'(HTRANS), 32'h0);
        chk({tag, "_HADDR"}, HADDR, 32'h0);
        chk({tag, "_HWRITE"}, 32'(HWRITE), 32'h0);
        chk({tag, "_HBURST"}, 32'(HBURST), 32'h0);
        chk({tag, "_HSIZE"}, 32'(HSIZE), 32'h2);
        chk({tag, "_HWDATA"}, HWDATA, 32'h0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
        chk({tag, "_rd_data"}, rd_data, 32'h0);
        chk({tag, "_rd_beat"}, 32'(rd_beat), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_done_err"}, 32'(done_err), 32'h0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
        #1;
        check_reset_vals("mid_rst");
        busy = 1'b0; err_seen = 1'b0; dp_active = 1'b0; slv_err2 = 1'b0;
        k = 0; beats = 1; wait_left = 0; gap = 0;
        exp_rd_valid = 1'b0; exp_done = 1'b0; exp_done_err = 1'b0;
        repeat (2) begin
            @(negedge HCLK);
            chk("rst_done", 32'(done), 32'h0);
            chk("rst_HTRANS", 32'(HTRANS), 32'h0);
        end
        HRESETn = 1'b1;
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_burst4 = 1'b0;
        cmd_addr = '0; cmd_wdata = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 2'b00;
        busy = 1'b0; err_seen = 1'b0; dp_active = 1'b0; slv_err2 = 1'b0; rnd_mode = 1'b0;
        k = 0; beats = 1; dp_beat = 0; wait_left = 0; gap = 0;
        exp_rd_valid = 1'b0; exp_done = 1'b0; exp_done_err = 1'b0;
        exp_rd_data = '0; exp_rd_beat = '0;
        cur = mk(1'b0, 1'b0, 32'h0, 128'h0, -1, -1, 0);

        repeat (2) @(negedge HCLK);
        check_reset_vals("por");
        HRESETn = 1'b1;

        // single write, zero wait states
        cmd_q.push_back(mk(1'b1, 1'b0, 32'h100, 128'hDEADBEEF, -1, -1, 0));
        drain(50);
        // INCR4 read with two wait states on one beat
        cmd_q.push_back(mk(1'b0, 1'b1, 32'h200, 128'h0, -1, 2, 2));
        drain(50);
        // single read answered with ERROR
        cmd_q.push_back(mk(1'b0, 1'b0, 32'h104, 128'h0, 0, -1, 0));
        drain(50);
        // INCR4 write, ERROR on beat 1 cancels the rest
        cmd_q.push_back(mk(1'b1, 1'b1, 32'h300,
                           128'h44444444_33333333_22222222_11111111, 1, -1, 0));
        drain(50);
        // unaligned addresses are forced to word / 16-byte alignment
        cmd_q.push_back(mk(1'b1, 1'b1, 32'h507, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, -1, -1, 0));
        cmd_q.push_back(mk(1'b0, 1'b0, 32'h603, 128'h0, -1, -1, 0));
        drain(80);

        // reset while beat 2 of a burst is in its data phase
        cmd_q.push_back(mk(1'b0, 1'b1, 32'h400, 128'h0, -1, -1, 0));
        for (int i = 0; i < 50 && !(busy && dp_active && dp_beat == 2); i++) step();
        chk("reach_beat2", 32'(busy && dp_active && dp_beat == 2), 32'h1);
        do_reset();
        cmd_q.push_back(mk(1'b1, 1'b0, 32'h700, 128'hCAFEF00D, -1, -1, 0));
        drain(50);

        // back-to-back single reads with cmd_valid held
        cmd_q.push_back(mk(1'b0, 1'b0, 32'h800, 128'h0, -1, -1, 0));
        cmd_q.push_back(mk(1'b0, 1'b0, 32'h804, 128'h0, -1, -1, 0));
        drain(50);

        // random traffic, waits, errors and stray responses
        rnd_mode = 1'b1;
        for (int r = 0; r < 80; r++) begin
            int n;
            n = int'($urandom_range(1, 3));
            for (int j = 0; j < n; j++) cmd_q.push_back(rand_cmd());
            drain(400);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
